// File: rtl/uart_msg_tx.sv
// uart_msg_tx: reads msg_len bytes from a registered-read buffer and sends them as
// LSB-first UART frames. Define UART_MSG_TX_PARITY_EN to add an even-parity bit.
module uart_msg_tx #(
    parameter int  WIDTH        = 8,
    parameter int  LEN          = 256,
    parameter int  CLKS_PER_BIT = 868,
    localparam int AW           = $clog2(LEN - 1) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             msg_valid,
    input  logic [AW-1:0]    msg_len,
    output logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] rdata,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef UART_MSG_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   len;
    logic [AW-1:0]   idx;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]   baud_cnt;
    logic [CW-1:0]   bit_cnt;
    logic            bit_end;
    logic            last_byte;
`ifdef UART_MSG_TX_PARITY_EN
    logic            parity_bit;
`endif

    assign bit_end   = (baud_cnt == BAUD_LAST);
    // idx+1 is compared before idx advances, so msg_len == LEN never wraps.
    assign last_byte = ((idx + AW'(1)) == len);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: default assigned first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (msg_valid && msg_len != '0) state_next = FETCH;
            FETCH: state_next = LOAD;
            LOAD:  state_next = START;
            START: if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end && bit_cnt == BIT_LAST) begin
`ifdef UART_MSG_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_MSG_TX_PARITY_EN
            PARITY: if (bit_end) state_next = STOP;
`endif
            STOP:  if (bit_end) state_next = last_byte ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
        end else if (bit_end || state == IDLE || state == FETCH || state == LOAD) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            raddr   <= '0;
            len     <= '0;
            idx     <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
`ifdef UART_MSG_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (msg_valid) begin
                        len   <= msg_len;
                        idx   <= '0;
                        raddr <= '0;
                        if (msg_len != '0) busy <= 1'b1;
                        else               done <= 1'b1;
                    end
                end
                LOAD: begin
                    shreg   <= rdata;
                    tx      <= 1'b0;
                    bit_cnt <= '0;
`ifdef UART_MSG_TX_PARITY_EN
                    parity_bit <= ^rdata;
`endif
                end
                START: begin
                    if (bit_end) begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_MSG_TX_PARITY_EN
                            tx <= parity_bit;
`else
                            tx <= 1'b1;
`endif
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_MSG_TX_PARITY_EN
                PARITY: if (bit_end) tx <= 1'b1;
`endif
                STOP: begin
                    if (bit_end) begin
                        if (last_byte) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            idx   <= idx + 1'b1;
                            raddr <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_tx.sv
// tb_uart_msg_tx: directed stimulus with a frame-decoding monitor and an
// expected-byte queue for uart_msg_tx (CLKS_PER_BIT=4, 1-cycle-latency RAM).
module tb_uart_msg_tx;
    localparam int C  = 4;
    localparam int W  = 8;
`ifdef UART_MSG_TX_PARITY_EN
    localparam int FB = W + 3;
`else
    localparam int FB = W + 2;
`endif
    localparam int FRAME_CYC = FB * C + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       msg_valid;
    logic [8:0] msg_len;
    logic [8:0] raddr;
    logic [7:0] rdata;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] mem [256];
    logic [8:0] q [$];

    int vectors     = 0;
    int miscompares = 0;
    int busy_cnt    = 0;
    int done_cnt    = 0;
    int rx_cnt      = 0;

    uart_msg_tx #(.WIDTH(8), .LEN(256), .CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .msg_valid(msg_valid),
        .msg_len  (msg_len),
        .raddr    (raddr),
        .rdata    (rdata),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[raddr[7:0]];

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] exp_of(input logic [7:0] b);
`ifdef UART_MSG_TX_PARITY_EN
        return {^b, b};
`else
        return {1'b0, b};
`endif
    endfunction

    // Called on a negedge; msg_valid is sampled by the next posedge (edge k),
    // and the task returns on the negedge just after edge k.
    task automatic pulse_valid(input logic [8:0] len);
        msg_valid = 1'b1;
        msg_len   = len;
        @(negedge clk);
        msg_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
    endtask

    // Frame decoder: detects a falling tx edge, checks the start bit stays low,
    // samples each following bit once, then pops and compares the expectation.
    initial begin : rx_mon
        logic       prev;
        logic       aborted;
        logic       start_ok;
        logic       stop_bit;
        logic       par;
        logic [7:0] data;
        logic [8:0] exp;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                prev = 1'b1;
            end else if (prev === 1'b1 && tx === 1'b0) begin
                aborted  = 1'b0;
                start_ok = 1'b1;
                stop_bit = 1'b0;
                par      = 1'b0;
                data     = '0;
                for (int s = 1; s < FB; s++) begin
                    for (int k = 0; k < C; k++) begin
                        if (!aborted) begin
                            if (s == 1 && tx !== 1'b0) start_ok = 1'b0;
                            @(negedge clk);
                            if (rst === 1'b1) aborted = 1'b1;
                        end
                    end
                    if (!aborted) begin
                        if (s <= W)          data[s-1] = tx;
                        else if (s == FB - 1) stop_bit = tx;
                        else                 par = tx;
                    end
                end
                if (aborted) begin
                    prev = 1'b1;
                end else begin
                    check("rx_start_low", start_ok, 1);
                    check("rx_stop_bit", stop_bit, 1);
                    check("rx_expected_pending", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        exp = q.pop_front();
                        check("rx_byte", {par, data}, exp);
                    end
                    rx_cnt++;
                    prev = tx;
                end
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int  b_busy, b_done, b_rx;
        logic bad;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst       = 1'b1;
        msg_valid = 1'b0;
        msg_len   = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {tx, busy, done, raddr}, {1'b1, 1'b0, 1'b0, 9'd0});
        rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_outputs", {tx, busy, done, raddr}, {1'b1, 1'b0, 1'b0, 9'd0});
        end

        // 2: "AB\n", latency, busy length, single done
        mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h0A;
        q.push_back(exp_of(8'h41));
        q.push_back(exp_of(8'h42));
        q.push_back(exp_of(8'h0A));
        b_busy = busy_cnt; b_done = done_cnt; b_rx = rx_cnt;
        pulse_valid(9'd3);
        check("t2_busy_accept", busy, 1);
        check("t2_tx_k", tx, 1);
        @(negedge clk);
        check("t2_tx_k1", tx, 1);
        @(negedge clk);
        check("t2_tx_k2_start", tx, 0);
        wait_done(3 * FRAME_CYC + 50);
        check("t2_raddr_hold", raddr, 2);
        check("t2_busy_at_done", busy, 0);
        repeat (20) @(negedge clk);
        check("t2_busy_cycles", busy_cnt - b_busy, 3 * FRAME_CYC);
        check("t2_done_pulses", done_cnt - b_done, 1);
        check("t2_frames", rx_cnt - b_rx, 3);
        check("t2_queue_empty", q.size(), 0);

        // 3: zero-length message
        b_done = done_cnt; b_rx = rx_cnt;
        pulse_valid(9'd0);
        check("t3_done_next", done, 1);
        check("t3_raddr", raddr, 0);
        check("t3_tx", tx, 1);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || raddr !== 9'd0) bad = 1'b1;
        end
        check("t3_tx_raddr_stable", bad, 0);
        check("t3_busy_after", busy, 0);
        check("t3_done_pulses", done_cnt - b_done, 1);
        check("t3_no_frames", rx_cnt - b_rx, 0);

        // 4: msg_valid mid-frame is ignored
        mem[0] = 8'h55; mem[1] = 8'hC3;
        q.push_back(exp_of(8'h55));
        q.push_back(exp_of(8'hC3));
        b_busy = busy_cnt; b_done = done_cnt; b_rx = rx_cnt;
        pulse_valid(9'd2);
        repeat (15) @(negedge clk);
        pulse_valid(9'd5);
        wait_done(2 * FRAME_CYC + 50);
        repeat (30) @(negedge clk);
        check("t4_busy_after", busy, 0);
        check("t4_busy_cycles", busy_cnt - b_busy, 2 * FRAME_CYC);
        check("t4_done_pulses", done_cnt - b_done, 1);
        check("t4_frames", rx_cnt - b_rx, 2);
        check("t4_queue_empty", q.size(), 0);

        // 5: reset during data bit 3 of the first byte (0x55: bit 3 is 0)
        b_done = done_cnt; b_rx = rx_cnt;
        pulse_valid(9'd2);
        repeat (19) @(negedge clk);
        check("t5_data_bit3", tx, 0);
        rst = 1'b1;
        #1;
        check("t5_rst_tx", tx, 1);
        check("t5_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_idle_after_rst", {tx, busy, done, raddr}, {1'b1, 1'b0, 1'b0, 9'd0});
        check("t5_no_done", done_cnt - b_done, 0);
        check("t5_no_frames", rx_cnt - b_rx, 0);
        q.push_back(exp_of(8'h55));
        b_done = done_cnt; b_rx = rx_cnt;
        pulse_valid(9'd1);
        wait_done(FRAME_CYC + 50);
        repeat (20) @(negedge clk);
        check("t5_resend_frames", rx_cnt - b_rx, 1);
        check("t5_resend_done", done_cnt - b_done, 1);
        check("t5_queue_empty", q.size(), 0);

`ifdef UART_MSG_TX_PARITY_EN
        // 6: parity bit for 0x07 (odd weight) then 0x03 (even weight)
        mem[0] = 8'h07; mem[1] = 8'h03;
        q.push_back(9'h107);
        q.push_back(9'h003);
        b_busy = busy_cnt; b_done = done_cnt; b_rx = rx_cnt;
        pulse_valid(9'd2);
        wait_done(2 * FRAME_CYC + 50);
        repeat (30) @(negedge clk);
        check("t6_busy_cycles", busy_cnt - b_busy, 2 * (11 * C + 2));
        check("t6_done_pulses", done_cnt - b_done, 1);
        check("t6_frames", rx_cnt - b_rx, 2);
        check("t6_queue_empty", q.size(), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
